// File: rtl/fa_32.sv
// Registered 32-bit ripple adder (sum = a + b + cin) with carry-out and signed-overflow flags.
// Define FA_32_PIPE_EN for a two-stage version that splits the carry chain at bit 16.

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module fa_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    input  logic        in_valid,
    output logic [31:0] sum,
    output logic        cout,
    output logic        ovf,
    output logic        out_valid
);
`ifdef FA_32_PIPE_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif

    logic [31:0] op_a, op_b, ci, co, s;
    logic [15:0] a_hi, b_hi;
    logic        c_mid;
    logic [31:0] res_sum;
    logic        ld_out;
    logic [STAGES:1] vld_pipe;

    // Carry into bit 16 is broken out so the pipelined build can feed it from a register.
    assign op_a = {a_hi, a[15:0]};
    assign op_b = {b_hi, b[15:0]};
    assign ci   = {co[30:16], c_mid, co[14:0], cin};

    generate
        for (genvar i = 0; i < 32; i++) begin : g_cell
            fa_cell u_cell (
                .a  (op_a[i]),
                .b  (op_b[i]),
                .ci (ci[i]),
                .s  (s[i]),
                .co (co[i])
            );
        end
    endgenerate

`ifdef FA_32_PIPE_EN
    logic [15:0] lo_q, a_hi_q, b_hi_q;
    logic        c16_q;

    // Stage 1 loads only on valid cycles so invalid (possibly X) operands never enter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q   <= '0;
            c16_q  <= 1'b0;
            a_hi_q <= '0;
            b_hi_q <= '0;
        end else if (in_valid) begin
            lo_q   <= s[15:0];
            c16_q  <= co[15];
            a_hi_q <= a[31:16];
            b_hi_q <= b[31:16];
        end
    end

    assign a_hi    = a_hi_q;
    assign b_hi    = b_hi_q;
    assign c_mid   = c16_q;
    assign res_sum = {s[31:16], lo_q};
    assign ld_out  = vld_pipe[1];
`else
    assign a_hi    = a[31:16];
    assign b_hi    = b[31:16];
    assign c_mid   = co[15];
    assign res_sum = s;
    assign ld_out  = in_valid;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= in_valid;
            for (int k = 2; k <= STAGES; k++)
                vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (ld_out) begin
            sum  <= res_sum;
            cout <= co[31];
            ovf  <= ci[31] ^ co[31];
        end
    end

    assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_fa_32.sv
// Directed and random checks of fa_32; expected results travel through a bench-side
// delay line of the build's latency, and hold values are tracked across bubbles.

module tb_fa_32;
`ifdef FA_32_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic        cin, in_valid;
    logic [31:0] sum;
    logic        cout, ovf, out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] dl_sum  [LAT];
    logic        dl_cout [LAT];
    logic        dl_ovf  [LAT];
    logic        dl_v    [LAT];
    string       dl_tag  [LAT];
    logic [31:0] h_sum;
    logic        h_cout, h_ovf;

    fa_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic clear_dl();
        for (int i = 0; i < LAT; i++) begin
            dl_v[i] = 1'b0; dl_sum[i] = '0; dl_cout[i] = 1'b0; dl_ovf[i] = 1'b0; dl_tag[i] = "idle";
        end
        h_sum = '0; h_cout = 1'b0; h_ovf = 1'b0;
    endtask

    // Drive one cycle, then check whatever result should be emerging after this edge.
    task automatic step(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                        input logic tv, input logic [31:0] es, input logic ec,
                        input logic eo, input string tag);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; in_valid = tv;
        @(posedge clk);
        #1;
        for (int i = LAT - 1; i > 0; i--) begin
            dl_sum[i] = dl_sum[i-1]; dl_cout[i] = dl_cout[i-1];
            dl_ovf[i] = dl_ovf[i-1]; dl_v[i] = dl_v[i-1]; dl_tag[i] = dl_tag[i-1];
        end
        dl_sum[0] = es; dl_cout[0] = ec; dl_ovf[0] = eo; dl_v[0] = tv; dl_tag[0] = tag;
        chk({dl_tag[LAT-1], ".out_valid"}, {31'b0, out_valid}, {31'b0, dl_v[LAT-1]});
        if (dl_v[LAT-1]) begin
            h_sum = dl_sum[LAT-1]; h_cout = dl_cout[LAT-1]; h_ovf = dl_ovf[LAT-1];
        end
        chk({dl_tag[LAT-1], ".sum"},  sum,               h_sum);
        chk({dl_tag[LAT-1], ".cout"}, {31'b0, cout},     {31'b0, h_cout});
        chk({dl_tag[LAT-1], ".ovf"},  {31'b0, ovf},      {31'b0, h_ovf});
    endtask

    task automatic rnd_step(input logic tv);
        logic [31:0] ra, rb;
        logic        rc, so;
        logic [32:0] full;
        ra = $urandom; rb = $urandom; rc = 1'($urandom_range(1));
        full = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
        so = (ra[31] == rb[31]) && (full[31] != ra[31]);
        step(ra, rb, rc, tv, full[31:0], full[32], so, "rand");
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".sum"},       sum,                '0);
        chk({tag, ".cout"},      {31'b0, cout},      '0);
        chk({tag, ".ovf"},       {31'b0, ovf},       '0);
        chk({tag, ".out_valid"}, {31'b0, out_valid}, '0);
    endtask

    initial begin
        rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0;
        clear_dl();
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        step(32'h00000001, 32'h00000000, 1'b0, 1'b1, 32'h00000001, 1'b0, 1'b0, "one");
        step(32'h00000001, 32'h00000000, 1'b1, 1'b1, 32'h00000002, 1'b0, 1'b0, "one_cin");
        step(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, "wrap");
        step(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, "all_ones");
        step(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, "pos_ovf");
        step(32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b1, "neg_ovf");
        step(32'h12345678, 32'h0FEDCBA9, 1'b1, 1'b1, 32'h22222222, 1'b0, 1'b0, "mixed");
        step('x, 'x, 1'bx, 1'b0, '0, 1'b0, 1'b0, "bubble_x");
        step('x, 'x, 1'bx, 1'b0, '0, 1'b0, 1'b0, "bubble_x2");
        step(32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, "mid_carry");
        step(32'h0000FFFF, 32'h00000001, 1'b0, 1'b1, 32'h00010000, 1'b0, 1'b0, "c16");

        // Reset asserted between edges with a non-zero result on the outputs.
        #2;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk_zero("mid_reset");
        clear_dl();
        @(negedge clk);
        rst_n = 1'b1;
        step(32'h00000003, 32'h00000004, 1'b1, 1'b1, 32'h00000008, 1'b0, 1'b0, "post_reset");
        step(32'h40000000, 32'h40000000, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, "post_reset2");

        for (int n = 0; n < 10000; n++)
            rnd_step($urandom_range(7) != 0);
        for (int n = 0; n < LAT; n++)
            step('x, 'x, 1'bx, 1'b0, '0, 1'b0, 1'b0, "drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
